// File: rtl/fifo_rd_gray_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_gray_ctrl_if
//   Output stream of the async FIFO read side (src_rdy/dst_rdy handshake).
//
//   Signals:
//     dst_data     data word, valid while dst_src_rdy is high
//     dst_src_rdy  source (FIFO) has a word to offer
//     dst_dst_rdy  downstream accepts the word this cycle
//
//   Modports:
//     master  the FIFO read controller (drives data/valid, samples ready)
//     slave   the downstream consumer
// -----------------------------------------------------------------------------
interface fifo_rd_gray_ctrl_if #(
    parameter int DWIDTH = 36
);
    logic [DWIDTH-1:0] dst_data;
    logic              dst_src_rdy;
    logic              dst_dst_rdy;

    modport master (
        output dst_data,
        output dst_src_rdy,
        input  dst_dst_rdy
    );

    modport slave (
        input  dst_data,
        input  dst_src_rdy,
        output dst_dst_rdy
    );
endinterface

// File: rtl/fifo_rd_gray_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_gray_ctrl
//   Read-side controller of an async FIFO. Synchronizes the gray-coded write
//   pointer, compares it with the local read pointer, drives the dual-port RAM
//   read port and presents the words first-word-fall-through on a
//   src_rdy/dst_rdy stream through a two-entry output buffer. The read pointer
//   is returned gray-coded and registered for the write side.
//
//   Parameters:
//     AWIDTH  RAM address width (depth 2^AWIDTH, pointers AWIDTH+1 bits)
//     DWIDTH  data width
//
//   Ports:
//     clk, rst_n    read-domain clock, asynchronous active-low reset
//     wr_gray_in    write pointer (gray), asynchronous to clk
//     rd_gray_out   read pointer (gray), registered
//     ram_raddr     RAM read address
//     ram_ren       RAM read enable (data returns one cycle later)
//     ram_rdata     RAM read data
//     dst           output stream (fifo_rd_gray_ctrl_if.master)
//     occupied      RAM entries written but not yet read (registered)
//     err           sticky gray-transition / overflow flag
//
//   Build option:
//     FIFO_RD_GRAY_CHECK_EN  when defined, builds the err checker; otherwise
//                            err is tied to 0.
// -----------------------------------------------------------------------------
module fifo_rd_gray_ctrl #(
    parameter int AWIDTH = 9,
    parameter int DWIDTH = 36
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [AWIDTH:0]      wr_gray_in,
    output logic [AWIDTH:0]      rd_gray_out,
    output logic [AWIDTH-1:0]    ram_raddr,
    output logic                 ram_ren,
    input  logic [DWIDTH-1:0]    ram_rdata,
    fifo_rd_gray_ctrl_if.master  dst,
    output logic [AWIDTH:0]      occupied,
    output logic                 err
);

    localparam logic [AWIDTH:0] PTR_ONE = {{AWIDTH{1'b0}}, 1'b1};

    function automatic logic [AWIDTH:0] gray2bin(input logic [AWIDTH:0] g);
        logic [AWIDTH:0] b;
        b[AWIDTH] = g[AWIDTH];
        for (int i = AWIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [AWIDTH:0] bin2gray(input logic [AWIDTH:0] b);
        return b ^ (b >> 1);
    endfunction

    // Pointer crossing and read pointer
    logic [AWIDTH:0]   r_wsync1;
    logic [AWIDTH:0]   r_wsync2;
    logic [AWIDTH:0]   r_wr_bin;
    logic [AWIDTH:0]   r_rd_bin;
    logic [AWIDTH:0]   r_rd_gray;
    logic [AWIDTH:0]   r_occupied;
    logic              r_inflight;

    // Output buffer: head is presented, skid catches the word already in
    // flight from the RAM when the consumer stalls.
    logic [1:0]        r_cnt;
    logic [DWIDTH-1:0] r_head;
    logic [DWIDTH-1:0] r_skid;

    logic              w_empty;
    logic              w_pop;
    logic [2:0]        w_level;
    logic              w_ren;

    // NOTE: every signal assigned in an always_comb gets a value on every
    // path (here: plain full assignments); a missed path infers a latch.
    always_comb begin
        w_empty = (r_wr_bin == r_rd_bin);
        w_pop   = (r_cnt != 2'd0) && dst.dst_dst_rdy;
        // Words the buffer will hold after this edge if nothing new is issued.
        w_level = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_ren   = !w_empty && (w_level < 3'd2);
    end

    // Two-flop synchronizer; only the second stage is ever decoded.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wsync1 <= '0;
            r_wsync2 <= '0;
            r_wr_bin <= '0;
        end else begin
            r_wsync1 <= wr_gray_in;
            r_wsync2 <= r_wsync1;
            r_wr_bin <= gray2bin(r_wsync2);
        end
    end

    // Read pointer, its gray image for the write side, and occupancy.
    // Modulo arithmetic over AWIDTH+1 bits handles pointer wrap directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_bin   <= '0;
            r_rd_gray  <= '0;
            r_occupied <= '0;
            r_inflight <= 1'b0;
        end else begin
            if (w_ren) begin
                r_rd_bin <= r_rd_bin + PTR_ONE;
            end
            r_rd_gray  <= bin2gray(r_rd_bin);
            r_occupied <= r_wr_bin - r_rd_bin;
            r_inflight <= w_ren;
        end
    end

    // Output buffer. Issue control guarantees cnt + inflight <= 2, so a load
    // never arrives while both entries are full and not being popped.
    // NOTE: the data registers are reset (not left as plain storage) because
    // dst_data must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 2'd0;
            r_head <= '0;
            r_skid <= '0;
        end else begin
            unique case ({r_inflight, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_head <= ram_rdata;
                    end else begin
                        r_skid <= ram_rdata;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_head <= r_skid;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    // Load and pop together: count holds, order preserved.
                    if (r_cnt == 2'd1) begin
                        r_head <= ram_rdata;
                    end else begin
                        r_head <= r_skid;
                        r_skid <= ram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FIFO_RD_GRAY_CHECK_EN
    localparam logic [AWIDTH:0] DEPTH = {1'b1, {AWIDTH{1'b0}}};

    logic [AWIDTH:0] r_wprev;
    logic            r_err;
    logic [AWIDTH:0] w_wdiff;
    logic            w_multi_bit;

    always_comb begin
        w_wdiff     = r_wsync2 ^ r_wprev;
        // More than one bit set: clearing the lowest set bit leaves some.
        w_multi_bit = ((w_wdiff & (w_wdiff - PTR_ONE)) != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wprev <= '0;
            r_err   <= 1'b0;
        end else begin
            r_wprev <= r_wsync2;
            if (w_multi_bit || (r_occupied > DEPTH)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign ram_ren         = w_ren;
    assign ram_raddr       = r_rd_bin[AWIDTH-1:0];
    assign rd_gray_out     = r_rd_gray;
    assign occupied        = r_occupied;
    assign dst.dst_src_rdy = (r_cnt != 2'd0);
    assign dst.dst_data    = r_head;

endmodule

// File: tb/tb_fifo_rd_gray_ctrl.sv
module tb_fifo_rd_gray_ctrl;

    localparam int AWIDTH = 9;
    localparam int DWIDTH = 36;
`ifdef FIFO_RD_GRAY_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [AWIDTH:0]   wr_gray_in;
    logic [AWIDTH:0]   rd_gray_out;
    logic [AWIDTH-1:0] ram_raddr;
    logic              ram_ren;
    logic [DWIDTH-1:0] ram_rdata;
    logic [AWIDTH:0]   occupied;
    logic              err;

    fifo_rd_gray_ctrl_if #(.DWIDTH(DWIDTH)) dst_if ();

    fifo_rd_gray_ctrl #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_gray_in  (wr_gray_in),
        .rd_gray_out (rd_gray_out),
        .ram_raddr   (ram_raddr),
        .ram_ren     (ram_ren),
        .ram_rdata   (ram_rdata),
        .dst         (dst_if),
        .occupied    (occupied),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Dual-port RAM model: one-cycle read latency.
    logic [DWIDTH-1:0] mem [1 << AWIDTH];
    always @(posedge clk) begin
        if (ram_ren) ram_rdata <= mem[ram_raddr];
    end

    int n_checks = 0;
    int n_pass   = 0;
    logic [DWIDTH-1:0] exp_q [$];
    int wp = 0;

    // Monitor state
    logic              cnt_clr = 1'b0;
    int                ren_cnt = 0;
    int                run = 0;
    int                max_run = 0;
    logic [AWIDTH-1:0] exp_raddr = '0;
    logic              hold_prev = 1'b0;
    logic [DWIDTH-1:0] hold_data = '0;

    function automatic logic [AWIDTH:0] g2b(input logic [AWIDTH:0] g);
        logic [AWIDTH:0] b;
        b[AWIDTH] = g[AWIDTH];
        for (int i = AWIDTH - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [AWIDTH:0] b2g(input logic [AWIDTH:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [DWIDTH-1:0] data_of(input int i);
        logic [15:0] v;
        v = i[15:0];
        return {4'hA, v, ~v};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counters();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_gray_in = '0;
        dst_if.dst_dst_rdy = 1'b0;
        exp_q.delete();
        wp = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Writer: one word per clock, never more than the RAM depth ahead.
    task automatic write_word();
        int g;
        logic [AWIDTH:0] diff;
        g = 0;
        diff = AWIDTH'(0);
        forever begin
            diff = (AWIDTH+1)'(wp) - g2b(rd_gray_out);
            if (diff < (AWIDTH+1)'(1 << AWIDTH) || g >= 200) break;
            tick();
            g++;
        end
        if (g >= 200) check("space_timeout", 1, 0);
        mem[wp % (1 << AWIDTH)] = data_of(wp);
        exp_q.push_back(data_of(wp));
        wp++;
        wr_gray_in = b2g((AWIDTH+1)'(wp));
        tick();
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 3000) begin
            tick();
            g++;
        end
        check("drain_left", exp_q.size(), 0);
        repeat (3) tick();
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_raddr = '0;
            hold_prev = 1'b0;
        end else begin
            if (cnt_clr) begin
                ren_cnt = 0;
                run     = 0;
                max_run = 0;
            end
            if (ram_ren) begin
                check("raddr", ram_raddr, exp_raddr);
                exp_raddr = exp_raddr + 1'b1;
                ren_cnt++;
            end
            if (hold_prev && dst_if.dst_src_rdy) check("hold_stable", dst_if.dst_data, hold_data);
            hold_prev = dst_if.dst_src_rdy && !dst_if.dst_dst_rdy;
            hold_data = dst_if.dst_data;
            if (dst_if.dst_src_rdy && dst_if.dst_dst_rdy) begin
                if (exp_q.size() == 0) check("unexpected_word", 1, 0);
                else check("data", dst_if.dst_data, exp_q.pop_front());
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values with a nonzero pointer at the input.
        rst_n = 1'b0;
        wr_gray_in = 10'h005;
        dst_if.dst_dst_rdy = 1'b0;
        repeat (3) tick();
        check("rst_rd_gray", rd_gray_out, 0);
        check("rst_occupied", occupied, 0);
        check("rst_ren", ram_ren, 0);
        check("rst_src_rdy", dst_if.dst_src_rdy, 0);
        check("rst_err", err, 0);
        check("rst_data", dst_if.dst_data, 0);
        check("rst_raddr", ram_raddr, 0);
        rst_n = 1'b1;
        tick(); check("ren_after_e1", ram_ren, 0);
        tick(); check("ren_after_e2", ram_ren, 0);
        tick(); check("ren_after_e3", ram_ren, 1);
        rst_n = 1'b0;
        #1 check("ren_async_rst", ram_ren, 0);
        do_reset();

        // Single word.
        dst_if.dst_dst_rdy = 1'b1;
        mem[0] = data_of(0);
        exp_q.push_back(data_of(0));
        wp = 1;
        wr_gray_in = 10'h001;
        tick(); check("single_ren_e1", ram_ren, 0);
        tick(); check("single_ren_e2", ram_ren, 0);
        tick(); check("single_ren_e3", ram_ren, 1);
        check("single_raddr", ram_raddr, 0);
        check("single_occ_e3", occupied, 0);
        tick(); check("single_ren_e4", ram_ren, 0);
        check("single_occ_e4", occupied, 1);
        check("single_src_e4", dst_if.dst_src_rdy, 0);
        tick(); check("single_src_e5", dst_if.dst_src_rdy, 1);
        check("single_data", dst_if.dst_data, data_of(0));
        check("single_occ_e5", occupied, 0);
        check("single_rd_gray", rd_gray_out, 10'h001);
        tick(); check("single_src_e6", dst_if.dst_src_rdy, 0);
        drain();

        // Streaming 16 words from reset.
        do_reset();
        dst_if.dst_dst_rdy = 1'b1;
        clr_counters();
        repeat (16) write_word();
        drain();
        check("stream_back_to_back", max_run, 16);
        check("stream_ren_count", ren_cnt, 16);
        check("stream_rd_gray", rd_gray_out, 10'h018);
        check("stream_occ", occupied, 0);

        // Backpressure: 8 words offered, consumer stalled 10+ clocks.
        dst_if.dst_dst_rdy = 1'b0;
        clr_counters();
        repeat (8) write_word();
        repeat (10) tick();
        check("bp_ren_count", ren_cnt, 2);
        check("bp_src_rdy", dst_if.dst_src_rdy, 1);
        check("bp_head", dst_if.dst_data, data_of(16));
        check("bp_occ", occupied, 6);
        dst_if.dst_dst_rdy = 1'b1;
        drain();
        check("bp_ren_total", ren_cnt, 8);

        // Wrap: bring pointers to 1020, then cross 1023 -> 0 under stall.
        while (wp < 1020) write_word();
        drain();
        check("wrap_pre_occ", occupied, 0);
        check("wrap_pre_rd_gray", rd_gray_out, b2g(10'd1020));
        dst_if.dst_dst_rdy = 1'b0;
        clr_counters();
        repeat (6) write_word();
        repeat (10) tick();
        check("wrap_occ", occupied, 4);
        check("wrap_ren_count", ren_cnt, 2);
        check("wrap_src_rdy", dst_if.dst_src_rdy, 1);
        dst_if.dst_dst_rdy = 1'b1;
        drain();
        repeat (4) write_word();
        drain();
        check("wrap_post_occ", occupied, 0);
        check("wrap_post_rd_gray", rd_gray_out, 10'h005);
        check("err_clean", err, 0);

        // Illegal gray jump 0x000 -> 0x003, then legal steps.
        do_reset();
        check("err_after_reset", err, 0);
        wr_gray_in = 10'h003;
        repeat (4) tick();
        check("err_jump", err, CHK_EN);
        wr_gray_in = 10'h002; tick();
        wr_gray_in = 10'h006; tick();
        repeat (3) tick();
        check("err_sticky", err, CHK_EN);
        rst_n = 1'b0;
        #1 check("err_cleared", err, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_rd_gray_ctrl.md
Name: fifo_rd_gray_ctrl

Overview:
Read-side controller of an async FIFO and the consumer end of the gray-coded pointer crossing.
- Receives the write pointer as raw gray code from the write clock domain and synchronizes it.
- Converts it to binary and compares it with its own read pointer to drive the dual-port RAM read port.
- Presents data on a src_rdy/dst_rdy output stream.
- Returns its own read pointer, gray-coded and registered, for the write side to synchronize.

Parameters:
AWIDTH, 9, RAM address width; FIFO depth = 2^AWIDTH; pointers are AWIDTH+1 bits (extra wrap bit).
DWIDTH, 36, data width.

Ports:
clk  in  1  read-domain clock.
rst_n  in  1  asynchronous active-low reset.
wr_gray_in  in  AWIDTH+1  write pointer, gray-coded, launched from the write clock domain (asynchronous to clk).
rd_gray_out  out  AWIDTH+1  read pointer, gray-coded, registered, for the write side.
ram_raddr  out  AWIDTH  RAM read address (low AWIDTH bits of the read pointer).
ram_ren  out  1  RAM read enable; 1-cycle read latency.
ram_rdata  in  DWIDTH  RAM read data, valid the cycle after ram_ren.
dst_data  out  DWIDTH  output data.
dst_src_rdy  out  1  output valid.
dst_dst_rdy  in  1  downstream ready.
occupied  out  AWIDTH+1  entries in the RAM not yet read (excludes the output buffer).
err  out  1  sticky error flag (see Optional Feature).

Behaviour:
- Reset (rst_n low, asynchronous): all flops clear.
  - Pointers are 0; rd_gray_out, occupied, ram_ren, dst_src_rdy and err are 0.
  - The output buffer is empty and dst_data is 0.
- Synchronizer: wr_gray_in passes through two flops (wsync1, wsync2).
  - Only wsync2 is used.
  - gray2bin(wsync2) is registered into wr_bin.
  - A write pointer change at wr_gray_in is therefore visible in wr_bin after 3 clk edges.
- Empty and occupancy:
  - empty = (wr_bin == rd_bin), compared over the full AWIDTH+1 bits.
  - occupied is registered: wr_bin - rd_bin, modulo 2^(AWIDTH+1).
  - Pointer wrap from 2^(AWIDTH+1)-1 to 0 must give correct empty and occupied values, with no special casing.
- Read issue:
  - cnt = entries in the 2-entry output buffer.
  - inflight = ram_ren was asserted in the previous cycle.
  - pop = dst_src_rdy & dst_dst_rdy.
  - ram_ren = !empty && (cnt + inflight - pop) < 2. This is combinational from registered state plus dst_dst_rdy.
  - When ram_ren is high, rd_bin increments at the clock edge.
  - ram_raddr = rd_bin[AWIDTH-1:0].
- rd_gray_out = bin2gray(rd_bin), registered.
  - It lags a pointer increment by 1 cycle.
  - It never changes more than 1 bit per clk.
- Output buffer:
  - Two-entry FIFO (head and skid) loaded from ram_rdata when inflight is set.
  - dst_src_rdy = (cnt != 0); dst_data = head entry.
  - A simultaneous load and pop in the same cycle keeps cnt unchanged and preserves order.
  - Sustained throughput is 1 word/clk when the RAM holds data and dst_dst_rdy is held high.
  - Data is first-word-fall-through. First word latency:
    - wr_gray_in change to ram_ren: 3 clk.
    - ram_ren to dst_src_rdy: 2 clk.
- Backpressure:
  - With dst_dst_rdy low, at most 2 words are held (cnt + inflight ≤ 2).
  - dst_data stays stable while dst_src_rdy is high and dst_dst_rdy is low.
- Reset mid-operation: all state clears immediately. Buffered data is discarded. The write side must be reset together with this block.

Optional Feature:
FIFO_RD_GRAY_CHECK_EN
- Defined:
  - err is set and held until reset when consecutive wsync2 samples differ in more than one bit (illegal gray transition).
  - err is also set when the registered occupied value exceeds 2^AWIDTH (overflow).
  - Flow control is unaffected by err.
- Not defined: err is tied to 0 and no check logic is built.

Test Plan:
- Reset: hold rst_n=0, drive wr_gray_in=0x005 -> all outputs 0. After release, ram_ren is 0 until 3 edges have passed.
- Single word (AWIDTH=9): wr_gray_in 0 -> bin2gray(1)=0x001, dst_dst_rdy=1.
  - ram_ren pulses once, with ram_raddr=0.
  - dst_src_rdy rises 2 clk later with that word; occupied goes 0->1->0.
  - rd_gray_out=0x001 one cycle after ram_ren.
- Streaming: step wr_gray_in through gray codes 1..16, one per clk, with dst_dst_rdy=1.
  - 16 words are output in order and back-to-back after the initial latency.
  - Final rd_gray_out=bin2gray(16)=0x018.
- Backpressure: 8 words available, dst_dst_rdy=0 for 10 clk.
  - Exactly 2 ram_ren pulses; dst_data is stable.
  - After dst_dst_rdy=1, the remaining 6 words follow with no loss or duplication.
- Wrap: preload both pointers near 1023 (AWIDTH=9) by streaming 1020 words, then stream 10 more.
  - The pointers cross 1023 -> 0; empty and occupied stay correct.
  - ram_raddr wraps 511 -> 0 at the RAM boundary.
- Check (macro on): wr_gray_in jumps 0x000 -> 0x003 -> err=1, and it stays 1 through further legal traffic until rst_n=0.
